// File: rtl/if_stage_if.sv
// Fetch packet type handed to decode, and the instruction-memory request/response bus of if_stage.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } rv32_if_packet_t;
endpackage

interface if_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/if_stage.sv
// RV32 instruction fetch stage: PC, credit-limited imem requests, in-order fetch queue, redirect flush.
// Defining IF_STAGE_STATS_EN adds the stat_fetched / stat_redirects / stat_dropped counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  if_stage_if.master      imem,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output rv32_if_packet_t if_packet
`ifdef IF_STAGE_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_redirects,
  output logic [31:0]     stat_dropped
`endif
);

  localparam int            PW      = $clog2(FQ_DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FQ_DEPTH);
  localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [31:0]         r_pc;
  logic [PW:0]         r_alloc;
  logic [PW:0]         r_fill;
  logic [PW:0]         r_read;
  logic [PW:0]         r_drop_cnt;
  logic [FQ_DEPTH-1:0] r_filled;
  logic [31:0]         r_pc_mem    [FQ_DEPTH];
  logic [31:0]         r_instr_mem [FQ_DEPTH];

  logic [PW:0]   w_inflight;
  logic [PW:0]   w_occupancy;
  logic [PW:0]   w_drop_sum;
  logic [PW:0]   w_drop_redirect;
  logic [PW+1:0] w_credit_used;
  logic [PW-1:0] w_alloc_idx;
  logic [PW-1:0] w_fill_idx;
  logic [PW-1:0] w_read_idx;
  logic          w_req_fire;
  logic          w_rsp_drop;
  logic          w_rsp_fill;
  logic          w_deq;
  logic          w_unused;

  assign w_inflight    = r_alloc - r_fill;
  assign w_occupancy   = r_alloc - r_read;
  assign w_credit_used = {1'b0, w_occupancy} + {1'b0, r_drop_cnt};
  assign w_alloc_idx   = r_alloc[PW-1:0];
  assign w_fill_idx    = r_fill[PW-1:0];
  assign w_read_idx    = r_read[PW-1:0];
  assign w_unused      = ^redirect_pc[1:0];

  // Stale responses still owed by memory hold a credit, so a full queue always has room for them.
  assign imem.req_valid = rst_n && !redirect_valid && (w_credit_used < DEPTH_W);
  assign imem.req_addr  = r_pc;
  assign w_req_fire     = imem.req_valid && imem.req_ready;

  assign w_rsp_drop = imem.rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_fill = imem.rsp_valid && (r_drop_cnt == '0) && (w_inflight != '0);

  assign if_valid  = r_filled[w_read_idx];
  assign if_packet = '{pc: r_pc_mem[w_read_idx], instruction: r_instr_mem[w_read_idx]};
  assign w_deq     = if_valid && if_ready;

  // A response landing in the redirect cycle is one of the stale ones and is counted off at once.
  assign w_drop_sum      = r_drop_cnt + w_inflight;
  assign w_drop_redirect = (imem.rsp_valid && (w_drop_sum != '0)) ? (w_drop_sum - PTR_ONE)
                                                                  : w_drop_sum;

  // NOTE: the entry arrays are reset as well, because if_packet reads them directly and must be '0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_read     <= '0;
      r_drop_cnt <= '0;
      r_filled   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_fill     <= r_alloc;
      r_read     <= r_alloc;
      r_drop_cnt <= w_drop_redirect;
      r_filled   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else begin
      // Alloc, fill and read never target the same slot in one cycle, given the credit rule.
      if (w_req_fire) begin
        r_pc_mem[w_alloc_idx]    <= r_pc;
        r_instr_mem[w_alloc_idx] <= '0;
        r_filled[w_alloc_idx]    <= 1'b0;
        r_alloc                  <= r_alloc + PTR_ONE;
        r_pc                     <= r_pc + 32'd4;
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - PTR_ONE;
      end
      if (w_rsp_fill) begin
        r_instr_mem[w_fill_idx] <= imem.rsp_data;
        r_filled[w_fill_idx]    <= 1'b1;
        r_fill                  <= r_fill + PTR_ONE;
      end
      if (w_deq) begin
        r_filled[w_read_idx]    <= 1'b0;
        r_pc_mem[w_read_idx]    <= '0;
        r_instr_mem[w_read_idx] <= '0;
        r_read                  <= r_read + PTR_ONE;
      end
    end
  end

`ifndef SYNTHESIS
  a_rsp_expected : assert property (@(posedge clk) disable iff (!rst_n)
    imem.rsp_valid |-> ((r_drop_cnt != '0) || (w_inflight != '0)))
    else $error("if_stage: imem response with nothing outstanding");
`endif

`ifdef IF_STAGE_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_redirects;
  logic [31:0] r_stat_dropped;
  logic        w_rsp_discard;

  assign w_rsp_discard = imem.rsp_valid &&
                         ((r_drop_cnt != '0) || (redirect_valid && (w_inflight != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetched   <= '0;
      r_stat_redirects <= '0;
      r_stat_dropped   <= '0;
    end else begin
      if (w_deq)          r_stat_fetched   <= r_stat_fetched + 32'd1;
      if (redirect_valid) r_stat_redirects <= r_stat_redirects + 32'd1;
      if (w_rsp_discard)  r_stat_dropped   <= r_stat_dropped + 32'd1;
    end
  end

  assign stat_fetched   = r_stat_fetched;
  assign stat_redirects = r_stat_redirects;
  assign stat_dropped   = r_stat_dropped;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run, checked against a program-order
// fetch/decode model and an in-order variable-latency memory.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int FQ_DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            if_valid;
  logic            if_ready;
  rv32_if_packet_t if_packet;
`ifdef IF_STAGE_STATS_EN
  logic [31:0]     stat_fetched;
  logic [31:0]     stat_redirects;
  logic [31:0]     stat_dropped;
`endif

  if_stage_if imem ();

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_packet      (if_packet)
`ifdef IF_STAGE_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_redirects (stat_redirects),
    .stat_dropped   (stat_dropped)
`endif
  );

  int              n_vec = 0;
  int              n_err = 0;
  int              cyc   = 0;
  int              last_due;
  int              lat_min, lat_max;
  mreq_t           mem_q[$];
  logic [31:0]     exp_fetch_pc, exp_dec_pc;
  logic            hold_pend;
  rv32_if_packet_t hold_pkt;
  logic            s_req_valid, s_if_valid, s_fire, s_hs, s_rsp;
  logic [31:0]     s_req_addr;
  rv32_if_packet_t s_pkt;

  function automatic logic [31:0] insn_of(logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + {a[7:0], a[31:8]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are sampled and checked, then the edge.
  task automatic cycle();
    int d;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = insn_of(mem_q[0].addr);
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = '0;
    end
    #2;
    s_req_valid = imem.req_valid;
    s_req_addr  = imem.req_addr;
    s_if_valid  = if_valid;
    s_pkt       = if_packet;
    s_rsp       = imem.rsp_valid;
    s_fire      = s_req_valid && imem.req_ready;
    s_hs        = s_if_valid && if_ready;

    chk("credit", 64'(mem_q.size() <= FQ_DEPTH), 64'd1);
    if (hold_pend) begin
      chk("hold_valid", 64'(s_if_valid), 64'd1);
      chk("hold_pkt", s_pkt, hold_pkt);
    end
    if (s_req_valid) chk("req_addr", 64'(s_req_addr), 64'(exp_fetch_pc));
    if (redirect_valid) chk("req_in_redirect", 64'(s_req_valid), 64'd0);
    if (s_hs) begin
      chk("dec_pc", 64'(s_pkt.pc), 64'(exp_dec_pc));
      chk("dec_insn", 64'(s_pkt.instruction), 64'(insn_of(exp_dec_pc)));
      exp_dec_pc = exp_dec_pc + 32'd4;
    end
    if (s_fire) exp_fetch_pc = exp_fetch_pc + 32'd4;
    if (redirect_valid) begin
      exp_fetch_pc = {redirect_pc[31:2], 2'b00};
      exp_dec_pc   = {redirect_pc[31:2], 2'b00};
    end
    hold_pend = s_if_valid && !if_ready && !redirect_valid;
    hold_pkt  = s_pkt;

    @(posedge clk);
    if (s_rsp) void'(mem_q.pop_front());
    if (s_fire) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: s_req_addr, due: d});
    end
    @(negedge clk);
    cyc++;
  endtask

  // Asserts reset at the current time, checks outputs at once, releases two negedges later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem.req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_packet", if_packet, 64'd0);
    mem_q.delete();
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    exp_fetch_pc = 32'h0;
    exp_dec_pc   = 32'h0;
    hold_pend    = 1'b0;
    last_due     = cyc;
  endtask

  initial begin
    int   n_req;
    logic found, bad;

    // NOTE: bench stimulus uses blocking assignments; the DUT samples them at the next posedge.
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    lat_min = 1;
    lat_max = 1;
    #3;
    do_reset();

    // Streaming from reset: one instruction per cycle after two cycles of fill latency.
    imem.req_ready = 1'b1;
    if_ready       = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k == 0) begin
        chk("t1_first_req", 64'(s_req_valid), 64'd1);
        chk("t1_first_addr", 64'(s_req_addr), 64'h0);
      end
      if (k < 2) chk("t1_fill_lat", 64'(s_if_valid), 64'd0);
      else begin
        chk("t1_valid", 64'(s_if_valid), 64'd1);
        chk("t1_pc", 64'(s_pkt.pc), 64'(4 * (k - 2)));
      end
    end

    // Decode stalled: exactly FQ_DEPTH requests, head stays at pc 0, resumes at 0x10.
    #3;
    do_reset();
    if_ready = 1'b0;
    n_req    = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_fire) n_req++;
    end
    chk("t2_req_count", 64'(n_req), 64'(FQ_DEPTH));
    chk("t2_req_off", 64'(s_req_valid), 64'd0);
    chk("t2_head_valid", 64'(s_if_valid), 64'd1);
    chk("t2_head_pc", 64'(s_pkt.pc), 64'h0);
    if_ready = 1'b1;
    found    = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cycle();
      found = s_fire;
    end
    chk("t2_resume_seen", 64'(found), 64'd1);
    chk("t2_resume_addr", 64'(s_req_addr), 64'h10);

    // Latency 3, three requests in flight, redirect to an unaligned target.
    #3;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    cycle();
    chk("t3_no_req", 64'(s_req_valid), 64'd0);
    redirect_valid = 1'b0;
    cycle();
    chk("t3_target_req", 64'(s_req_valid), 64'd1);
    chk("t3_target_addr", 64'(s_req_addr), 64'h1000);
    chk("t3_flushed", 64'(s_if_valid), 64'd0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cycle();
      found = s_if_valid;
    end
    chk("t3_first_seen", 64'(found), 64'd1);
    chk("t3_first_pc", 64'(s_pkt.pc), 64'h1000);

    // Redirect coinciding with a response and a decode handshake.
    #3;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (6) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0804;
    cycle();
    chk("t4_handshake", 64'(s_hs), 64'd1);
    chk("t4_response", 64'(s_rsp), 64'd1);
    chk("t4_no_req", 64'(s_req_valid), 64'd0);
    redirect_valid = 1'b0;
    cycle();
    chk("t4_flushed", 64'(s_if_valid), 64'd0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      found = s_if_valid;
    end
    chk("t4_first_seen", 64'(found), 64'd1);
    chk("t4_first_pc", 64'(s_pkt.pc), 64'h804);

    // Two redirects one idle cycle apart: nothing from 0x200 may reach decode.
    #3;
    do_reset();
    lat_min = 2;
    lat_max = 2;
    repeat (4) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    cycle();
    redirect_valid = 1'b0;
    found = 1'b0;
    bad   = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      if (s_hs && !found) begin
        found = 1'b1;
        chk("t5_first_pc", 64'(s_pkt.pc), 64'h300);
      end
      if (s_hs && s_pkt.pc >= 32'h200 && s_pkt.pc < 32'h300) bad = 1'b1;
    end
    chk("t5_first_seen", 64'(found), 64'd1);
    chk("t5_no_stale", 64'(bad), 64'd0);

    // Async reset mid-cycle with the queue full, then restart from RESET_PC.
    #3;
    do_reset();
    lat_min  = 1;
    lat_max  = 1;
    if_ready = 1'b0;
    repeat (8) cycle();
    chk("t6_full_valid", 64'(s_if_valid), 64'd1);
    chk("t6_full_noreq", 64'(s_req_valid), 64'd0);
    #3;
    do_reset();
    if_ready = 1'b1;
    cycle();
    chk("t6_restart_req", 64'(s_req_valid), 64'd1);
    chk("t6_restart_addr", 64'(s_req_addr), 64'h0);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cycle();
      found = s_if_valid;
    end
    chk("t6_restart_seen", 64'(found), 64'd1);
    chk("t6_restart_pc", 64'(s_pkt.pc), 64'h0);

    // Randomized traffic: stalls on both sides, variable latency, sporadic redirects.
    #3;
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 800; k++) begin
      imem.req_ready = ($urandom_range(99, 0) < 75);
      if_ready       = ($urandom_range(99, 0) < 70);
      redirect_valid = ($urandom_range(99, 0) < 4);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    imem.req_ready = 1'b1;
    if_ready       = 1'b1;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
